// File: rtl/bayer_window_3x3.sv
// Raw Bayer AXI4-Stream to 3x3 window stream. Two line buffers plus a 3x3 shift
// register; interior windows leave through a single output register.
module bayer_window_3x3 #(
  parameter int PX_WIDTH    = 10,
  parameter int FRAME_RES_X = 1920,
  parameter int FRAME_RES_Y = 1080
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            pattern_i,
  input  logic                  video_tvalid_i,
  output logic                  video_tready_o,
  input  logic [PX_WIDTH-1:0]   video_tdata_i,
  input  logic                  video_tuser_i,
  input  logic                  video_tlast_i,
  output logic                  win_valid_o,
  input  logic                  win_ready_i,
  output logic [9*PX_WIDTH-1:0] win_data_o,
  output logic [1:0]            win_phase_o,
  output logic                  win_en_o,
  output logic                  win_sof_o,
  output logic                  win_eol_o
);
  localparam int CW = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int RW = (FRAME_RES_Y > 1) ? $clog2(FRAME_RES_Y) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(FRAME_RES_X - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(FRAME_RES_Y - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_sat;
  logic          r_en_sh;
  logic [1:0]    r_pat_sh;

  logic [PX_WIDTH-1:0] r_lb0 [FRAME_RES_X];
  logic [PX_WIDTH-1:0] r_lb1 [FRAME_RES_X];
  logic [2:0][2:0][PX_WIDTH-1:0] r_sh;

  logic       r_valid;
  logic [1:0] r_phase;
  logic       r_en;
  logic       r_sof;
  logic       r_eol;

  logic                w_acc;
  logic [CW-1:0]       w_col;
  logic [RW-1:0]       w_row;
  logic                w_ovf;
  logic                w_win;
  logic                w_en;
  logic [1:0]          w_pat;
  logic [PX_WIDTH-1:0] w_lb0;
  logic [PX_WIDTH-1:0] w_lb1;

  assign video_tready_o = !r_valid || win_ready_i;
  assign w_acc = video_tvalid_i && video_tready_o;

  // tuser restarts the frame on this very pixel, so it sees col=row=0
  assign w_col = video_tuser_i ? '0 : r_col;
  assign w_row = video_tuser_i ? '0 : r_row;
  assign w_ovf = r_sat && !video_tuser_i;
  assign w_en  = video_tuser_i ? en_i : r_en_sh;
  assign w_pat = video_tuser_i ? pattern_i : r_pat_sh;
  assign w_win = !w_ovf && (w_col >= CW'(2)) && (w_row >= RW'(2));

  assign w_lb0 = r_lb0[w_col];
  assign w_lb1 = r_lb1[w_col];

  always_ff @(posedge clk_i) begin
    if (w_acc && !w_ovf) begin
      r_lb0[w_col] <= video_tdata_i;
      r_lb1[w_col] <= w_lb0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_col    <= '0;
      r_row    <= '0;
      r_sat    <= 1'b0;
      r_en_sh  <= 1'b0;
      r_pat_sh <= 2'd0;
      r_sh     <= '0;
      r_valid  <= 1'b0;
      r_phase  <= 2'd0;
      r_en     <= 1'b0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
    end else begin
      if (w_acc) begin
        if (video_tuser_i) begin
          r_en_sh  <= en_i;
          r_pat_sh <= pattern_i;
        end
        if (video_tlast_i) begin
          r_col <= '0;
          r_sat <= 1'b0;
          r_row <= (w_row == ROW_MAX) ? w_row : w_row + RW'(1);
        end else if (w_col == COL_MAX) begin
          // past the buffer depth: hold col, mark following pixels as overflow
          r_col <= w_col;
          r_sat <= 1'b1;
          r_row <= w_row;
        end else begin
          r_col <= w_col + CW'(1);
          r_sat <= 1'b0;
          r_row <= w_row;
        end
        if (!w_ovf) begin
          r_sh[0] <= {w_lb1, r_sh[0][2:1]};
          r_sh[1] <= {w_lb0, r_sh[1][2:1]};
          r_sh[2] <= {video_tdata_i, r_sh[2][2:1]};
        end
      end
      if (w_acc && w_win) begin
        r_valid <= 1'b1;
        // centre sits at (col-1,row-1): its parity is the inverse of the edge pixel's
        r_phase <= w_pat ^ {~w_row[0], ~w_col[0]};
        r_en    <= w_en;
        r_sof   <= (w_row == RW'(2)) && (w_col == CW'(2));
        r_eol   <= video_tlast_i;
      end else if (win_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign win_valid_o = r_valid;
  assign win_data_o  = r_sh;
  assign win_phase_o = r_phase;
  assign win_en_o    = r_en;
  assign win_sof_o   = r_sof;
  assign win_eol_o   = r_eol;
endmodule

// File: tb/tb_bayer_window_3x3.sv
// Randomized scoreboard bench for bayer_window_3x3: a line-history image model
// predicts each window; a monitor pops and compares on every output handshake.
module tb_bayer_window_3x3;
  localparam int PX = 10;
  localparam int XR = 8;
  localparam int YR = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            en_i;
  logic [1:0]      pattern_i;
  logic            tvalid;
  logic            tready;
  logic [PX-1:0]   tdata;
  logic            tuser;
  logic            tlast;
  logic            win_valid;
  logic            win_ready;
  logic [9*PX-1:0] win_data;
  logic [1:0]      win_phase;
  logic            win_en;
  logic            win_sof;
  logic            win_eol;

  always #5 clk = ~clk;

  bayer_window_3x3 #(.PX_WIDTH(PX), .FRAME_RES_X(XR), .FRAME_RES_Y(YR)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en_i), .pattern_i(pattern_i),
    .video_tvalid_i(tvalid), .video_tready_o(tready), .video_tdata_i(tdata),
    .video_tuser_i(tuser), .video_tlast_i(tlast),
    .win_valid_o(win_valid), .win_ready_i(win_ready), .win_data_o(win_data),
    .win_phase_o(win_phase), .win_en_o(win_en), .win_sof_o(win_sof), .win_eol_o(win_eol)
  );

  typedef struct {
    logic [9*PX-1:0] data;
    logic [1:0]      phase;
    logic            en;
    logic            sof;
    logic            eol;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_win = 0;
  int   rmode = 0;
  bit   gaps = 0;

  // image model: the three most recent lines of the stream
  logic [PX-1:0] prev2[XR];
  logic [PX-1:0] prev1[XR];
  logic [PX-1:0] cur[XR];
  int            mx, my;
  bit            msat;
  logic          men;
  logic [1:0]    mpat;

  logic [9*PX-1:0] first_data;
  logic [1:0]      first_phase;
  logic            first_sof;
  bit              got_first = 0;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; msat = 0; men = 1'b0; mpat = 2'd0;
  endtask

  task automatic model_accept(input logic [PX-1:0] d, input bit u, input bit l);
    int cx, cy;
    bit ovf;
    exp_t e;
    logic [PX-1:0] pix;
    cx  = u ? 0 : mx;
    cy  = u ? 0 : my;
    ovf = !u && msat;
    if (u) begin men = en_i; mpat = pattern_i; end
    if (!ovf) begin
      cur[cx] = d;
      if (cx >= 2 && cy >= 2) begin
        e.data = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            pix = (r == 0) ? prev2[cx-2+c] : (r == 1) ? prev1[cx-2+c] : cur[cx-2+c];
            e.data[PX*(3*r+c) +: PX] = pix;
          end
        e.phase = mpat ^ {logic'(((cy-1) % 2) != 0), logic'(((cx-1) % 2) != 0)};
        e.en    = men;
        e.sof   = (cx == 2 && cy == 2);
        e.eol   = l;
        exp_q.push_back(e);
      end
    end
    if (l) begin
      prev2 = prev1; prev1 = cur;
      mx = 0; msat = 0;
      my = (cy < YR-1) ? cy + 1 : cy;
    end else begin
      my = cy;
      if (cx == XR-1) begin mx = cx; msat = 1; end
      else begin mx = cx + 1; msat = 0; end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: win_ready = 1'b1;
        1: win_ready = ~win_ready;
        2: win_ready = 1'($urandom_range(0, 1));
        default: win_ready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && win_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_window data=%h phase=%0d", win_data, win_phase);
        end else begin
          e = exp_q[0];
          if (win_data !== e.data || win_phase !== e.phase || win_en !== e.en ||
              win_sof !== e.sof || win_eol !== e.eol) begin
            failures++;
            $display("FAIL window got data=%h ph=%0d en=%0b sof=%0b eol=%0b exp data=%h ph=%0d en=%0b sof=%0b eol=%0b",
                     win_data, win_phase, win_en, win_sof, win_eol, e.data, e.phase, e.en, e.sof, e.eol);
          end
          if (win_ready) begin
            if (!got_first) begin
              got_first = 1; first_data = win_data; first_phase = win_phase; first_sof = win_sof;
            end
            void'(exp_q.pop_front());
            n_win++;
          end
        end
      end
    end
  endtask

  // called at posedge+#1, returns at posedge+#1 after the handshake edge
  task automatic send_px(input logic [PX-1:0] d, input bit u, input bit l);
    int n;
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
    n = 0;
    @(negedge clk);
    while (!tready && n < 200) begin @(negedge clk); n++; end
    if (!tready) begin
      checks++; failures++;
      $display("FAIL accept_timeout tready=%0b exp=1", tready);
    end else model_accept(d, u, l);
    @(posedge clk); #1;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic send_line(input int w, input int y, input bit first, input bit last, input bit det);
    logic [PX-1:0] d;
    for (int x = 0; x < w; x++) begin
      d = det ? PX'(16*y + x) : PX'($urandom_range(0, (1 << PX) - 1));
      send_px(d, first && x == 0, last && x == w-1);
    end
  endtask

  task automatic send_frame(input int w, input int h, input bit det);
    for (int y = 0; y < h; y++) send_line(w, y, y == 0, 1'b1, det);
  endtask

  task automatic drain(input string nm, input int exp_n);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((exp_q.size() != 0 || win_valid) && n < 1000);
    chk({nm, "_drain"}, 96'(exp_q.size()), 96'(0));
    if (exp_n >= 0) chk({nm, "_count"}, 96'(n_win), 96'(exp_n));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [9*PX-1:0] d0;
    rst = 1'b1; en_i = 1'b0; pattern_i = 2'd0; tvalid = 1'b0; tdata = '0;
    tuser = 1'b0; tlast = 1'b0; win_ready = 1'b1;
    model_reset();
    fork
      ready_drv();
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 96'(win_valid), 96'(0));
    chk("rst_tready", 96'(tready), 96'(1));
    chk("rst_data", 96'(win_data), 96'(0));
    chk("rst_phase", 96'(win_phase), 96'(0));
    chk("rst_en", 96'(win_en), 96'(0));
    chk("rst_sof", 96'(win_sof), 96'(0));
    chk("rst_eol", 96'(win_eol), 96'(0));
    @(posedge clk); #1;

    // 6x4 ramp frame, pattern 2
    en_i = 1'b1; pattern_i = 2'd2; rmode = 0; n_win = 0;
    send_frame(6, 4, 1'b1);
    drain("frameA", 8);
    d0 = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) d0[PX*(3*r+c) +: PX] = PX'(16*r + c);
    chk("first_data", 96'(first_data), 96'(d0));
    chk("first_phase", 96'(first_phase), 96'(1));
    chk("first_sof", 96'(first_sof), 96'(1));

    // same frame with downstream ready toggling
    rmode = 1; n_win = 0;
    send_frame(6, 4, 1'b1);
    drain("frameA_stall", 8);

    // pattern/enable change mid-frame only takes effect next frame
    rmode = 2; gaps = 1; en_i = 1'b0; pattern_i = 2'd0; n_win = 0;
    send_line(6, 0, 1'b1, 1'b1, 1'b0);
    send_line(6, 1, 1'b0, 1'b1, 1'b0);
    en_i = 1'b1; pattern_i = 2'd3;
    send_line(6, 2, 1'b0, 1'b1, 1'b0);
    send_line(6, 3, 1'b0, 1'b1, 1'b0);
    send_frame(6, 4, 1'b0);
    drain("shadow", 16);

    // short last line
    pattern_i = 2'd1; n_win = 0;
    send_line(6, 0, 1'b1, 1'b1, 1'b0);
    send_line(6, 1, 1'b0, 1'b1, 1'b0);
    send_line(6, 2, 1'b0, 1'b1, 1'b0);
    send_line(4, 3, 1'b0, 1'b1, 1'b0);
    drain("short_line", 6);

    // tuser arriving at row 3 col 1
    n_win = 0;
    send_line(6, 0, 1'b1, 1'b1, 1'b0);
    send_line(6, 1, 1'b0, 1'b1, 1'b0);
    send_line(6, 2, 1'b0, 1'b1, 1'b0);
    send_line(1, 3, 1'b0, 1'b0, 1'b0);
    send_frame(6, 4, 1'b0);
    drain("resync", 12);

    // column saturation: 10-pixel line into 8-deep buffer
    n_win = 0;
    send_line(8, 0, 1'b1, 1'b1, 1'b0);
    send_line(8, 1, 1'b0, 1'b1, 1'b0);
    send_line(10, 2, 1'b0, 1'b1, 1'b0);
    send_line(8, 3, 1'b0, 1'b1, 1'b0);
    drain("col_sat", 12);

    // row saturation: 8 lines with 6-line counter range
    n_win = 0;
    send_frame(6, 8, 1'b0);
    drain("row_sat", 24);

    // random frames
    for (int f = 0; f < 6; f++) begin
      en_i = 1'($urandom_range(0, 1));
      pattern_i = 2'($urandom_range(0, 3));
      send_frame($urandom_range(3, XR), $urandom_range(3, 7), 1'b0);
    end
    drain("random", -1);

    // reset while a window is stalled at the output
    rmode = 3; gaps = 0;
    send_line(6, 0, 1'b1, 1'b1, 1'b0);
    send_line(6, 1, 1'b0, 1'b1, 1'b0);
    send_line(3, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 96'(win_valid), 96'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("midrst_valid", 96'(win_valid), 96'(0));
    chk("midrst_tready", 96'(tready), 96'(1));
    chk("midrst_en", 96'(win_en), 96'(0));
    chk("midrst_phase", 96'(win_phase), 96'(0));
    @(posedge clk); #1;
    rmode = 0; n_win = 0; en_i = 1'b1; pattern_i = 2'd2;
    send_frame(5, 4, 1'b0);
    drain("post_reset", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
